// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined -- single-stage instruction decode with operand bypass,
// immediate generation, optional load-use stall and a registered output slot.
//
// Build option: define ID_LOAD_USE_STALL_EN to enable load-use hazard
// detection. Without it the hazard is tied low and stall_cycles stays 0.
//
// Ports
//   clock, reset            : rising-edge clock, async active-high reset
//   in_valid/in_ready       : fetch-side handshake
//   in_instr, in_pc         : fetched instruction and its PC
//   rf_raddr1/2, rf_rdata1/2: combinational register-file read
//   byp_valid/rd/data       : NUM_BYP write-back bypass sources, index 0 youngest
//   ex_is_load, ex_rd       : instruction currently in EX (load-use detection)
//   flush                   : squash the decode and the output register
//   out_valid/out_ready     : EX-side handshake
//   out_*                   : registered decoded fields and operands
//   stall_cycles            : saturating count of hazard-stall cycles

// Per-operand select: lowest-index matching bypass wins, x0 always reads 0.
module id_opsel #(
  parameter int XLEN    = 32,
  parameter int NUM_BYP = 2
) (
  input  logic [4:0]              rs,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_BYP-1:0]      byp_valid,
  input  logic [5*NUM_BYP-1:0]    byp_rd,
  input  logic [XLEN*NUM_BYP-1:0] byp_data,
  output logic [XLEN-1:0]         op
);
  always_comb begin
    op = rf_data;
    // Walk oldest to youngest so the youngest match overwrites.
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp_valid[i] && byp_rd[i*5 +: 5] == rs) op = byp_data[i*XLEN +: XLEN];
    end
    if (rs == 5'd0) op = '0;
  end
endmodule

module id_stage_pipelined #(
  parameter int XLEN    = 32,
  parameter int NUM_BYP = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_BYP-1:0]      byp_valid,
  input  logic [5*NUM_BYP-1:0]    byp_rd,
  input  logic [XLEN*NUM_BYP-1:0] byp_data,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_opA,
  output logic [XLEN-1:0]         out_opB,
  output logic [XLEN-1:0]         out_imm,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_instr,
  output logic [6:0]              out_opcode,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic [2:0]              out_funct3,
  output logic [6:0]              out_funct7,
  output logic [15:0]             stall_cycles
);
  typedef struct packed {
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } dec_t;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  assign opcode = in_instr[6:0];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  // Operand select, one instance per source operand.
  logic [1:0][4:0]      rs_sel;
  logic [1:0][XLEN-1:0] rf_sel, op_sel;
  assign rs_sel = {rs2, rs1};
  assign rf_sel = {rf_rdata2, rf_rdata1};

  for (genvar g = 0; g < 2; g++) begin : g_op
    id_opsel #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_sel (
      .rs        (rs_sel[g]),
      .rf_data   (rf_sel[g]),
      .byp_valid (byp_valid),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .op        (op_sel[g])
    );
  end

  // Immediate generation, built at 32 bits then sign-extended to XLEN.
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  always_comb begin
    imm32 = '0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
      7'b0100011:
        imm32 = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
      7'b1100011:
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {in_instr[31:12], 12'b0};
      7'b1101111:
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm = XLEN'($signed(imm32));

  // Load-use hazard: rs2 only matters for opcodes that actually read it.
  logic hazard;
`ifdef ID_LOAD_USE_STALL_EN
  logic uses_rs2;
  assign uses_rs2 = (opcode == 7'b0110011) || (opcode == 7'b0100011) || (opcode == 7'b1100011);
  assign hazard   = ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1) || ((ex_rd == rs2) && uses_rs2));
`else
  logic unused_ex;
  assign unused_ex = ^{ex_is_load, ex_rd};
  assign hazard    = 1'b0;
`endif

  logic accept;
  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  dec_t dec_d, dec_q;
  assign dec_d = '{opa: op_sel[0], opb: op_sel[1], imm: imm, pc: in_pc, instr: in_instr};

  // Output slot. flush wins over everything; in_ready already excludes flush,
  // so the accept branch can never fire in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dec_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dec_q     <= dec_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (in_valid && hazard && !flush && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

  // Field outputs are slices of the registered instruction, so they are
  // registered too and read as zero after reset.
  assign out_opA    = dec_q.opa;
  assign out_opB    = dec_q.opb;
  assign out_imm    = dec_q.imm;
  assign out_pc     = dec_q.pc;
  assign out_instr  = dec_q.instr;
  assign out_opcode = dec_q.instr[6:0];
  assign out_rd     = dec_q.instr[11:7];
  assign out_funct3 = dec_q.instr[14:12];
  assign out_rs1    = dec_q.instr[19:15];
  assign out_rs2    = dec_q.instr[24:20];
  assign out_funct7 = dec_q.instr[31:25];
endmodule

// File: tb/tb_id_stage_pipelined.sv
module tb_id_stage_pipelined;
  localparam int XLEN = 32;
  localparam int NB   = 2;
`ifdef ID_LOAD_USE_STALL_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1;
  logic in_valid, in_ready, ex_is_load, flush, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [XLEN-1:0] in_pc, rf_rdata1, rf_rdata2, out_opA, out_opB, out_imm, out_pc;
  logic [4:0] rf_raddr1, rf_raddr2, ex_rd, out_rs1, out_rs2, out_rd;
  logic [NB-1:0] byp_valid;
  logic [5*NB-1:0] byp_rd;
  logic [XLEN*NB-1:0] byp_data;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  logic [15:0] stall_cycles;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  id_stage_pipelined #(.XLEN(XLEN), .NUM_BYP(NB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .byp_valid(byp_valid),
    .byp_rd(byp_rd), .byp_data(byp_data), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opA(out_opA),
    .out_opB(out_opB), .out_imm(out_imm), .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    in_valid = 0; in_instr = 0; in_pc = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    byp_valid = 0; byp_rd = 0; byp_data = 0; ex_is_load = 0; ex_rd = 0;
    flush = 0; out_ready = 0;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 0;

    // addi x1,x0,5
    in_instr = 32'h00500093; in_pc = 32'h100; in_valid = 1; out_ready = 1;
    rf_rdata1 = 32'h999; rf_rdata2 = 32'h777;
    #1;
    chk("raddr1", rf_raddr1, 0);
    chk("raddr2", rf_raddr2, 5);
    @(negedge clock);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_opA_x0", out_opA, 0);
    chk("addi_opB", out_opB, 32'h777);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_opcode", out_opcode, 7'h13);

    // addi x2,x3,-1 with two matching bypasses
    in_instr = 32'hFFF18113; rf_rdata1 = 7;
    byp_valid = 2'b11; byp_rd = {5'd3, 5'd3}; byp_data = {32'd22, 32'd11};
    @(negedge clock);
    chk("byp_youngest", out_opA, 11);
    chk("imm_neg1", out_imm, 32'hFFFFFFFF);
    chk("byp_rd", out_rd, 2);
    chk("byp_rs1", out_rs1, 3);
    byp_valid = 2'b10;
    @(negedge clock);
    chk("byp_older", out_opA, 22);
    byp_valid = 2'b11; byp_rd = {5'd4, 5'd4};
    @(negedge clock);
    chk("byp_nomatch_rf", out_opA, 7);
    in_instr = 32'h00000093; byp_rd = {5'd0, 5'd0};
    @(negedge clock);
    chk("byp_x0_ignored", out_opA, 0);
    byp_valid = 0;

    // immediate formats
    in_instr = 32'h0051A423; rf_rdata2 = 32'h55;   // sw x5,8(x3)
    @(negedge clock);
    chk("s_imm", out_imm, 8);
    chk("s_opB", out_opB, 32'h55);
    chk("s_funct3", out_funct3, 2);
    in_instr = 32'hFE208EE3;                       // beq x1,x2,-4
    @(negedge clock);
    chk("b_imm", out_imm, 32'hFFFFFFFC);
    in_instr = 32'h123452B7;                       // lui x5,0x12345
    @(negedge clock);
    chk("u_imm", out_imm, 32'h12345000);
    chk("u_rd", out_rd, 5);
    in_instr = 32'h008000EF;                       // jal x1,8
    @(negedge clock);
    chk("j_imm", out_imm, 8);
    in_instr = 32'h40520333;                       // sub x6,x4,x5
    @(negedge clock);
    chk("r_imm", out_imm, 0);
    chk("r_funct7", out_funct7, 7'h20);
    chk("r_rd", out_rd, 6);

    // load-use: addi whose rs2 field matches ex_rd is not a hazard
    ex_is_load = 1; ex_rd = 5; in_instr = 32'h00500093;
    #1 chk("nohz_addi_rs2", in_ready, 1);
    in_instr = 32'h00520333; in_pc = 32'h200;      // add x6,x4,x5
    for (int k = 0; k < 3; k++) begin
      #1 chk("hz_in_ready", in_ready, !HZ);
      @(negedge clock);
      chk("hz_out_valid", out_valid, !HZ);
    end
    chk("hz_stall3", stall_cycles, HZ ? 3 : 0);
    ex_is_load = 0;
    #1 chk("hz_release_ready", in_ready, 1);
    @(negedge clock);
    chk("hz_accept_valid", out_valid, 1);
    chk("hz_accept_rd", out_rd, 6);
    chk("hz_accept_pc", out_pc, 32'h200);

    // backpressure
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_instr = 32'h00500093 + (k << 7);
      #1 chk("bp_in_ready", in_ready, 0);
      @(negedge clock);
      chk("bp_valid", out_valid, 1);
      chk("bp_rd_hold", out_rd, 6);
      chk("bp_instr_hold", out_instr, 32'h00520333);
    end
    out_ready = 1; in_instr = 32'h123452B7;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge clock);
    chk("bp_new_rd", out_rd, 5);
    chk("bp_new_imm", out_imm, 32'h12345000);

    // flush during accept, with a hazard present: no stall count
    in_instr = 32'h00520333; ex_is_load = 1; ex_rd = 5; flush = 1;
    #1 chk("fl_in_ready", in_ready, 0);
    @(negedge clock);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_stall_hold", stall_cycles, HZ ? 3 : 0);
    flush = 0; ex_is_load = 0; in_instr = 32'h00500093;
    @(negedge clock);
    chk("post_fl_valid", out_valid, 1);

    // reset mid-stall
    out_ready = 0; in_instr = 32'h00520333; ex_is_load = 1; ex_rd = 5;
    @(negedge clock);
    chk("ms_stall4", stall_cycles, HZ ? 4 : 0);
    chk("ms_valid_held", out_valid, 1);
    #2 reset = 1;
    #1;
    chk("ms_rst_valid", out_valid, 0);
    chk("ms_rst_stall", stall_cycles, 0);
    chk("ms_rst_rd", out_rd, 0);
    @(negedge clock);
    reset = 0; ex_is_load = 0; out_ready = 1; in_instr = 32'h008000EF;
    @(negedge clock);
    chk("first_accept_valid", out_valid, 1);
    chk("first_accept_rd", out_rd, 1);
    chk("first_accept_imm", out_imm, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_stage_pipelined.md
ID_STAGE_PIPELINED -- requirements
Module: id_stage_pipelined

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/operand width.
REQ-002 SHALL have parameter NUM_BYP, default 2, number of write-back bypass sources (1..4).
REQ-003 SHALL have ports: clock  input  1  single rising-edge clock.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  input  1  / in_ready  output  1  fetch-side handshake.
REQ-006 SHALL have ports: in_instr  input  32  / in_pc  input  XLEN  fetched instruction and its PC.
REQ-007 SHALL have ports: rf_raddr1, rf_raddr2  output  5  and rf_rdata1, rf_rdata2  input  XLEN  combinational register-file read.
REQ-008 SHALL have ports: byp_valid  input  NUM_BYP; byp_rd  input  5*NUM_BYP; byp_data  input  XLEN*NUM_BYP  bypass sources, index 0 youngest.
REQ-009 SHALL have ports: ex_is_load  input  1 / ex_rd  input  5  instruction currently in EX.
REQ-010 SHALL have ports: flush  input  1  squash decode and output register.
REQ-011 SHALL have ports: out_valid  output  1 / out_ready  input  1  EX-side handshake.
REQ-012 SHALL have ports: out_opA, out_opB, out_imm, out_pc  output  XLEN; out_instr  output  32; out_opcode  output  7; out_rs1, out_rs2, out_rd  output  5; out_funct3  output  3; out_funct7  output  7.
REQ-013 SHALL have ports: stall_cycles  output  16  saturating count of hazard-stall cycles.

Function
REQ-014 SHALL drive rf_raddr1/2 combinationally from in_instr[19:15]/[24:20].
REQ-015 SHALL select each operand from the lowest-index bypass i with byp_valid[i], byp_rd[i]==rs, rs!=0, else rf_rdata; rs==0 SHALL yield 0.
REQ-016 SHALL generate sign-extended out_imm by opcode: I (0010011, 0000011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits 0), J (1101111, bit0=0); others 0.
REQ-017 SHALL register all out_* fields; latency in-accept to out_valid = 1 cycle.
REQ-018 hazard SHALL be ex_is_load && ex_rd!=0 && (ex_rd==rs1 || (ex_rd==rs2 && opcode in {0110011, 0100011, 1100011})).
REQ-019 in_ready SHALL equal !hazard && !flush && (!out_valid || out_ready).
REQ-020 Transfer in SHALL occur when in_valid && in_ready; output register loads, out_valid=1.
REQ-021 When out_ready && !(in_valid && in_ready), out_valid SHALL clear next cycle (bubble).
REQ-022 When out_valid && !out_ready, all out_* SHALL hold stable.
REQ-023 flush SHALL clear out_valid next cycle, override any transfer, and not increment stall_cycles.
REQ-024 stall_cycles SHALL increment each cycle in_valid && hazard && !flush, saturating at 16'hFFFF.

Reset
REQ-025 reset SHALL asynchronously force out_valid=0, stall_cycles=0, all out_* data fields=0.
REQ-026 reset asserted mid-transfer SHALL discard the in-flight instruction; first accept is possible on the first clock edge after deassertion.

Configuration
REQ-027 With ID_LOAD_USE_STALL_EN defined, REQ-018 hazard detection SHALL be active.
REQ-028 Without ID_LOAD_USE_STALL_EN, hazard SHALL be constant 0 and stall_cycles SHALL remain 0.

Verification
REQ-029 Reset then addi x1,x0,5 (0x00500093) in_valid=1, out_ready=1 -> next cycle out_valid=1, out_rd=1, out_imm=5, out_opA=0.
REQ-030 rs1=3, rf_rdata1=7, byp_valid=2'b11, byp_rd={3,3}, byp_data={22,11} -> out_opA=11 (index 0 wins); byp_rd=0 match -> ignored.
REQ-031 ex_is_load=1, ex_rd=5, add using rs2=5 held 3 cycles (macro on) -> in_ready=0 for 3 cycles, out_valid bubbles, stall_cycles=3; macro off -> in_ready=1, stall_cycles=0.
REQ-032 out_ready=0 with out_valid=1 for 4 cycles, in_instr changing -> out_* unchanged, in_ready=0; out_ready=1 -> new instruction accepted.
REQ-033 flush=1 during accept -> out_valid=0 next cycle; reset asserted mid-stall -> out_valid=0, stall_cycles=0 immediately.
